// File: rtl/gray_step_decoder_pkg.sv
// gray_pkg: shared state type, bar-code table and Gray-to-binary helper.
package gray_pkg;
  typedef enum logic {INIT, TRACK} state_t;
  localparam logic [7:0][6:0] BAR_CODE = {
    7'b1000000, 7'b0100000, 7'b0010000, 7'b0001000,
    7'b0000100, 7'b0000010, 7'b0000001, 7'b0000000
  };
  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction
endpackage

// File: rtl/gray_step_decoder_code_to_index.sv
// code_to_index: decodes a 7-bit Gray or bar code word into an index and a legality flag.
module code_to_index
  import gray_pkg::*;
(
  input  logic [6:0] code,
  input  logic       use_gray,
  output logic [2:0] idx,
  output logic       legal
);
  always_comb begin
    idx = gray2bin(code[2:0]);
    legal = code[6:3] == 4'd0;
    if (!use_gray) begin
      idx = 3'd0;
      legal = 1'b0;
      for (int i = 0; i < 8; i++)
        if (code == BAR_CODE[i]) begin
          idx = 3'(i);
          legal = 1'b1;
        end
    end
  end
endmodule

// File: rtl/gray_step_decoder.sv
// gray_step_decoder: glitch-filtered index recovery with step tracking, position count and error flags.
module gray_step_decoder
  import gray_pkg::*;
#(
  parameter int STABLE_CNT = 2,
  parameter int POS_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       CODE,
  input  logic             USE_GRAY,
  input  logic             IN_VALID,
  input  logic             CLR_ERR,
  output logic [2:0]       A,
  output logic             OUT_VALID,
  output logic             STEP_UP,
  output logic             STEP_DN,
  output logic [POS_W-1:0] POS,
  output logic             ILLEGAL,
  output logic             ERR
);
  localparam logic [3:0] SAT = 4'(STABLE_CNT);
  state_t     state, state_e;
  logic       mode, mode_chg, legal, same, accept;
  logic [2:0] d, cand, cand_e, cand_n, delta;
  logic [3:0] cnt, cnt_e, cnt_n;
  code_to_index u_dec (.code(CODE), .use_gray(USE_GRAY), .idx(d), .legal(legal));
  // A mode change restarts the filter and state before the same sample is processed.
  always_comb begin
    mode_chg = USE_GRAY != mode;
    cand_e = mode_chg ? 3'd0 : cand;
    cnt_e = mode_chg ? 4'd0 : cnt;
    state_e = mode_chg ? INIT : state;
    same = d == cand_e;
    cnt_n = !legal ? 4'd0 : !same ? 4'd1 : cnt_e == SAT ? cnt_e : cnt_e + 4'd1;
    cand_n = legal ? d : cand_e;
    accept = legal && cnt_n == SAT && !(same && cnt_e == SAT);
    delta = d - A;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      mode <= 1'b0;
      cand <= 3'd0;
      cnt <= 4'd0;
      A <= 3'd0;
      OUT_VALID <= 1'b0;
      STEP_UP <= 1'b0;
      STEP_DN <= 1'b0;
      POS <= '0;
      ILLEGAL <= 1'b0;
      ERR <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      STEP_UP <= 1'b0;
      STEP_DN <= 1'b0;
      ILLEGAL <= 1'b0;
      if (CLR_ERR) ERR <= 1'b0;
      if (IN_VALID) begin
        mode <= USE_GRAY;
        cand <= cand_n;
        cnt <= cnt_n;
        state <= accept ? TRACK : state_e;
        if (!legal) begin
          ILLEGAL <= 1'b1;
          ERR <= 1'b1;
        end
        if (accept && (state_e == INIT || delta != 3'd0)) begin
          A <= d;
          OUT_VALID <= 1'b1;
          if (state_e == TRACK) begin
            if (delta == 3'd1) begin
              STEP_UP <= 1'b1;
              POS <= POS + POS_W'(1);
            end else if (delta == 3'd7) begin
              STEP_DN <= 1'b1;
              POS <= POS - POS_W'(1);
            end else ERR <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: doc/gray_step_decoder.md
Name: gray_step_decoder

Overview:
- Receive-side counterpart of the 3-bit index encoder: accepts the 7-bit code word driven toward the display path (Gray code or one-hot-style "bar" code) and recovers the 3-bit index.
- Filters glitches with a stability counter, tracks single-step motion (up/down), keeps a wrapping position count, and flags illegal codes and skipped steps.
- Sits between the code source (encoder output or external Gray-coded sensor) and the control/display logic.

Parameters:
- STABLE_CNT, 2, number of consecutive identical legal valid samples required before a new index is accepted (legal range 1..15).
- POS_W, 8, width of the signed position counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- CODE  input  7  code word to decode.
- USE_GRAY  input  1  1 selects Gray decoding on CODE[2:0]; 0 selects bar decoding.
- IN_VALID  input  1  CODE/USE_GRAY are sampled on edges where this is 1.
- CLR_ERR  input  1  clears the sticky ERR flag.
- A  output  3  last accepted index.
- OUT_VALID  output  1  one-cycle pulse when A is updated.
- STEP_UP  output  1  one-cycle pulse: accepted index = previous + 1 (mod 8).
- STEP_DN  output  1  one-cycle pulse: accepted index = previous - 1 (mod 8).
- POS  output  POS_W  two's-complement position; +1 per STEP_UP, -1 per STEP_DN, wraps silently.
- ILLEGAL  output  1  one-cycle pulse: sampled code was not legal in the current mode.
- ERR  output  1  sticky: set on ILLEGAL or on a skip; cleared by CLR_ERR.

Behaviour:
- Reset: all outputs 0, the filter is empty (candidate 0, count 0), the mode register is 0, and the state is INIT.
- Decode (combinational, internal). Gray mode: CODE[6:3] must be 0, b2=g2, b1=g2^g1, b0=b1^g0.
- Decode, bar mode: the only legal codes are 0000000->0, 0000001->1, 0000010->2, 0000100->3, 0001000->4, 0010000->5, 0100000->6, 1000000->7. Every other code is illegal.
- Everything is registered. A sample taken at edge k is reflected in the outputs after edge k, giving 1-cycle latency. All pulses last exactly one cycle.
- IN_VALID=0: no state change. Pulses return to 0.
- Mode change: a valid sample whose USE_GRAY differs from the stored mode:
  - stores the new mode, clears the filter and returns to INIT;
  - then processes that same sample as the first sample in INIT;
  - retains POS and A.
- Illegal valid sample: ILLEGAL=1, ERR=1, filter count cleared to 0. A, POS and state are unchanged.
- Legal valid sample, decoded value d:
  - if d equals the candidate, count increments, saturating at STABLE_CNT;
  - otherwise the candidate becomes d and count becomes 1.
- Acceptance fires on the sample where count reaches STABLE_CNT (after update). Samples at saturation do not re-fire.
- States: INIT, TRACK.
- INIT, on acceptance: A=d, OUT_VALID=1, no step pulse, POS unchanged, go to TRACK.
- TRACK, on acceptance with delta=(d-A) mod 8:
  - 0: nothing happens.
  - 1: STEP_UP, POS+1.
  - 7: STEP_DN, POS-1.
  - 2..6: skip. ERR=1, no step, POS unchanged.
  - In all nonzero cases A=d and OUT_VALID=1.
- Index wrap: 7->0 is an up-step and 0->7 is a down-step. POS wraps at 2^(POS_W-1) without a flag.
- Simultaneous CLR_ERR with an error event: the set wins, so ERR=1.
- Reset asserted mid-operation: outputs and state return immediately to reset values, asynchronously.

Decomposition:
- Shared package gray_pkg:
  - state typedef {INIT, TRACK};
  - the bar-code constant table, also usable by the encoder;
  - the function gray2bin(3 bits).
- One natural sub-module, code_to_index: combinational; takes CODE and USE_GRAY, returns index and legal. Reusable by the bench as a reference model.

Test Plan:
- Reset, Gray mode, STABLE_CNT=2: CODE 000,000 then 001,001 -> first pair: A=0, OUT_VALID, no step. Second pair: A=1, STEP_UP, POS=1.
- Gray sequence 0..7,0 (codes 000,001,011,010,110,111,101,100,000, each held 2 samples) -> 8 STEP_UP pulses, POS=8, A=0. Reverse the sequence -> POS back to 0.
- Glitch: accepted 3, then one sample of code 6 (110), then 3 held -> no OUT_VALID, A stays 3, POS unchanged.
- Bar mode: CODE 0000011 -> ILLEGAL pulse, ERR=1. Then CLR_ERR -> ERR=0. Then CLR_ERR coincident with another illegal code -> ERR stays 1.
- Skip: accepted 1, then bar code 0010000 held 2 samples -> A=5, OUT_VALID, ERR=1, no step, POS unchanged. Next: USE_GRAY toggled -> INIT, first acceptance gives no step.
- Async reset asserted between clock edges with POS=5 -> POS=0, A=0, ERR=0 immediately. Tracking restarts in INIT.
